// File: rtl/div_sequencer_pkg.sv
// Shared types, ALU op codes and helpers for the multi-cycle divide sequencer.
package div_sequencer_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ALU_OP = 5;

  // Divide-family ALU control codes; the remaining codes belong to the single-cycle ALU.
  localparam logic [ALU_OP-1:0] ALU_DIV  = 5'd12;
  localparam logic [ALU_OP-1:0] ALU_DIVU = 5'd13;
  localparam logic [ALU_OP-1:0] ALU_REM  = 5'd14;
  localparam logic [ALU_OP-1:0] ALU_REMU = 5'd15;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_CALC,
    DS_DONE
  } div_state_t;

  function automatic logic is_div_op(input logic [ALU_OP-1:0] op);
    logic hit;
    hit = 1'b0;
    unique case (op)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: hit = 1'b1;
      default:                              hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_signed_div_op(input logic [ALU_OP-1:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [ALU_OP-1:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divide sequencer handshake: request, operands, flush, stall and result.
interface div_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic                                   start;
  logic [div_sequencer_pkg::ALU_OP-1:0]   alu_ctrl;
  logic [WIDTH-1:0]                       op_a;
  logic [WIDTH-1:0]                       op_b;
  logic                                   flush;
  logic                                   stall;
  logic                                   result_valid;
  logic [WIDTH-1:0]                       result;

  // EX stage side
  modport master (
    output start, alu_ctrl, op_a, op_b, flush,
    input  stall, result_valid, result
  );

  // Sequencer side
  modport slave (
    input  start, alu_ctrl, op_a, op_b, flush,
    output stall, result_valid, result
  );

endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU controller: radix-2 restoring divide, one quotient bit per
// cycle, stalling IF/ID/EX until the result is ready.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  div_sequencer_if.slave   ex_io
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_rem_q, is_rem_d;

  logic             op_signed, op_rem, accept;
  logic             a_neg, b_neg, div_by_zero, overflow;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_nx, quo_nx, rem_fin, quo_fin;
  logic             stall;

  // Accept decode and operand magnitudes for the incoming request.
  always_comb begin
    op_signed   = is_signed_div_op(ex_io.alu_ctrl);
    op_rem      = is_rem_op(ex_io.alu_ctrl);
    accept      = (state_q == DS_IDLE) && ex_io.start && is_div_op(ex_io.alu_ctrl) &&
                  !ex_io.flush;
    a_neg       = op_signed && ex_io.op_a[WIDTH-1];
    b_neg       = op_signed && ex_io.op_b[WIDTH-1];
    a_mag       = a_neg ? (WIDTH'(0) - ex_io.op_a) : ex_io.op_a;
    b_mag       = b_neg ? (WIDTH'(0) - ex_io.op_b) : ex_io.op_b;
    div_by_zero = (ex_io.op_b == '0);
    overflow    = op_signed && (ex_io.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (ex_io.op_b == '1);
  end

  // One restoring step: shift {rem,quo} left, trial-subtract, keep difference if non-negative.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = !diff[WIDTH];
    rem_nx  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nx  = {quo_q[WIDTH-2:0], fits};
    quo_fin = neg_quo_q ? (WIDTH'(0) - quo_nx) : quo_nx;
    rem_fin = neg_rem_q ? (WIDTH'(0) - rem_nx) : rem_nx;
  end

  // FSM next state, datapath updates and stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    stall     = 1'b0;

    unique case (state_q)
      DS_IDLE: begin
        if (accept) begin
          stall     = 1'b1;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          is_rem_d  = op_rem;
          if (div_by_zero) begin
            // Result is known now, so it is registered on entry to DONE.
            result_d = op_rem ? ex_io.op_a : '1;
            state_d  = DS_DONE;
          end else if (overflow) begin
            result_d = op_rem ? '0 : ex_io.op_a;
            state_d  = DS_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = DS_CALC;
          end
        end
      end
      DS_CALC: begin
        if (ex_io.flush) begin
          state_d = DS_IDLE;
        end else begin
          stall = 1'b1;
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == '0) begin
            // Signs are applied as the last step's result is captured.
            result_d = is_rem_q ? rem_fin : quo_fin;
            state_d  = DS_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DS_DONE: begin
        state_d = DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DS_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

  // Outputs: result_valid comes straight from the DONE state.
  always_comb begin
    ex_io.stall        = stall;
    ex_io.result_valid = (state_q == DS_DONE);
    ex_io.result       = result_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: scoreboard of expected results and latencies.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .ex_io (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;

  typedef struct {
    string       tag;
    logic [4:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference divide semantics, written from the operation definitions.
  function automatic logic [31:0] ref_div(input logic [4:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (ctrl == ALU_DIV)       r = (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
    else if (ctrl == ALU_REM)  r = (b == 0) ? a : 32'($signed(a) % $signed(b));
    else if (ctrl == ALU_DIVU) r = (b == 0) ? 32'hFFFF_FFFF : a / b;
    else if (ctrl == ALU_REMU) r = (b == 0) ? a : a % b;
    return r;
  endfunction

  // Present a request for one cycle; optionally record the expected outcome.
  task automatic issue(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int lat,
                       input bit expect_res);
    exp_t e;
    bus.alu_ctrl = ctrl;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.flush    = 1'b0;
    bus.start    = 1'b1;
    #1;
    check({tag, "_acc_stall"}, 32'(bus.stall), 32'd1);
    if (expect_res) begin
      e.res = res;
      e.lat = lat;
      e.tag = tag;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Called one cycle after accept; waits for result_valid and compares with the scoreboard.
  task automatic wait_result();
    exp_t e;
    int   lat;
    int   nst;
    bit   got;
    lat = 1;
    nst = 0;
    got = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_size", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.result_valid) begin
        got = 1'b1;
      end else begin
        if (bus.stall) nst++;
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({e.tag, "_valid"}, 32'(got), 32'd1);
    if (got) begin
      check({e.tag, "_res"}, bus.result, e.res);
      check({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({e.tag, "_stall_cyc"}, 32'(nst), 32'(e.lat - 1));
      check({e.tag, "_done_stall"}, 32'(bus.stall), 32'd0);
    end
  endtask

  task automatic idle_cycle();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Count result_valid cycles over a window where no result may appear.
  task automatic expect_silence(input string tag, input int cycles);
    int nv;
    nv = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.result_valid) nv++;
      @(posedge clk);
      #1;
    end
    check(tag, 32'(nv), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.alu_ctrl = '0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    idle_cycle();

    vecs.push_back('{"div_100_7",     ALU_DIV,  32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{"rem_100_7",     ALU_REM,  32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{"div_m7_2",      ALU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{"rem_m7_2",      ALU_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{"divu_max_2",    ALU_DIVU, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  33});
    vecs.push_back('{"div_5_0",       ALU_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{"remu_5_0",      ALU_REMU, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{"rem_m5_0",      ALU_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1});
    vecs.push_back('{"div_ovf",       ALU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{"rem_ovf",       ALU_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
    vecs.push_back('{"divu_ovf_pat",  ALU_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});

    foreach (vecs[i]) begin
      issue(vecs[i].tag, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);
      wait_result();
      idle_cycle();
    end

    // Random operands against the reference model.
    for (int i = 0; i < 8; i++) begin
      logic [4:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      ctrl = 5'(ALU_DIV + 5'($urandom_range(0, 3)));
      a    = $urandom;
      b    = $urandom >> $urandom_range(0, 28);
      if (b == 0) b = 32'd3;
      if (a == 32'h8000_0000) a = 32'd1;
      issue($sformatf("rnd%0d", i), ctrl, a, b, ref_div(ctrl, a, b), 33, 1'b1);
      wait_result();
      idle_cycle();
    end

    // A non-divide op must not be accepted.
    bus.alu_ctrl = 5'd2;
    bus.start    = 1'b1;
    #1;
    check("nondiv_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    expect_silence("nondiv_valid", 40);

    // Flush at iteration 10 aborts the divide.
    issue("flush_calc", ALU_DIV, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    #1;
    check("flush_calc_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    expect_silence("flush_calc_valid", 40);

    // Flush together with start in IDLE: no accept.
    bus.alu_ctrl = ALU_DIV;
    bus.op_a     = 32'd100;
    bus.op_b     = 32'd7;
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    #1;
    check("flush_idle_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    expect_silence("flush_idle_valid", 40);

    // Reset mid-CALC clears everything immediately.
    issue("rst_calc", ALU_DIV, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 32'(bus.stall), 32'd0);
    check("rst_mid_valid", 32'(bus.result_valid), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();
    issue("div_9_3", ALU_DIV, 32'd9, 32'd3, 32'd3, 33, 1'b1);
    wait_result();
    idle_cycle();

    // Back-to-back: second request presented in DONE, accepted in the following IDLE cycle.
    issue("b2b_first", ALU_DIV, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    wait_result();
    bus.alu_ctrl = ALU_DIV;
    bus.op_a     = 32'd81;
    bus.op_b     = 32'd9;
    bus.start    = 1'b1;
    #1;
    check("b2b_done_start_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    issue("b2b_second", ALU_DIV, 32'd81, 32'd9, 32'd9, 33, 1'b1);
    wait_result();
    idle_cycle();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
